alu_md_sequencer: RTL and testbench
===================================

ALU_MD_SEQUENCER -- requirements
Module: alu_md_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values 8..64, even.
REQ-002 Parameter ALU_OP_W, default 3: width of ALU_Op_i.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 funct7_i  input  7  instruction funct7 field; bit 5 selects SUB/SRA, bit 0 selects RV32M.
REQ-006 funct3_i  input  3  instruction funct3 field.
REQ-007 ALU_Op_i  input  ALU_OP_W  class from main control: 000 R, 001 I-arith, 010 load/store, 011 branch, 100 LUI.
REQ-008 valid_i  input  1  current instruction is valid this cycle.
REQ-009 rs1_i, rs2_i  input  WIDTH each  operands for multi-cycle ops.
REQ-010 ALU_Operation_o  output  4  combinational ALU opcode.
REQ-011 stall_o  output  1  freeze PC and pipeline while a multiply/divide is outstanding.
REQ-012 md_done_o  output  1  one-cycle pulse: md_result_o is valid.
REQ-013 md_result_o  output  WIDTH  multiply/divide result, held until next accept.

Function
REQ-014 Decode: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASS_B 1010.
REQ-015 R-type uses funct3 plus funct7[5]; I-type ignores funct7[5] except SRAI; load/store -> ADD; branch -> SUB; LUI -> PASS_B; any unlisted combination -> ADD.
REQ-016 R-type with funct7 = 0000001 is an MD op (funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU); ALU_Operation_o = ADD for MD ops.
REQ-017 FSM states IDLE, CALC, DONE; IDLE -> CALC when valid_i and MD op decoded; operands, funct3 latched at that edge.
REQ-018 CALC lasts exactly WIDTH cycles: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; inputs ignored while in CALC.
REQ-019 CALC -> DONE after step WIDTH; DONE asserts md_done_o and writes md_result_o; DONE -> IDLE next cycle unconditionally.
REQ-020 stall_o = valid_i AND MD op decoded AND state != DONE; accept-to-done latency WIDTH+1 cycles.
REQ-021 Signed ops run on magnitudes; sign fixed in DONE; MULH/MULHSU/MULHU return upper WIDTH bits of 2*WIDTH product, MUL the lower.
REQ-022 Divide by zero: quotient all ones, remainder = dividend; signed overflow (MIN / -1): quotient MIN, remainder 0; both still take WIDTH+1 cycles.
REQ-023 valid_i with a non-MD op never changes FSM state.

Reset
REQ-024 reset low forces IDLE, md_result_o = 0, md_done_o = 0, stall_o follows REQ-020 from IDLE; takes effect immediately, including mid-CALC, discarding partial results.

Configuration
REQ-025 Macro ALU_MD_DIV_EN defined: DIV/DIVU/REM/REMU execute per REQ-018..022.
REQ-026 ALU_MD_DIV_EN undefined: divide hardware omitted; divide ops take IDLE -> DONE directly (1-cycle), md_result_o = 0; multiply unchanged.

Structure
REQ-027 Shared package holds ALU opcode constants, ALU_Op class encodings, MD funct3 encodings and FSM state encoding.
REQ-028 Iterative datapath is a sub-module md_iter_unit (operand/accumulator registers, step counter); alu_md_sequencer holds decode and FSM.

Verification
REQ-029 ALU_Op=000, funct7=0100000, funct3=000 -> ALU_Operation_o = 0001; ALU_Op=001, funct3=101, funct7=0100000 -> 0111.
REQ-030 MUL rs1=7, rs2=-3, WIDTH=32 -> stall_o high 33 cycles, md_done_o pulse on cycle 33, md_result_o = 0xFFFFFFEB.
REQ-031 MULHU rs1=rs2=0xFFFFFFFF -> md_result_o = 0xFFFFFFFE.
REQ-032 DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REMU rs1=9, rs2=0 -> 9; DIVU rs1=9, rs2=0 -> 0xFFFFFFFF.
REQ-033 reset low at cycle 10 of CALC -> state IDLE, md_result_o = 0, no md_done_o; next DIV 100/7 -> 14 after 33 cycles.
REQ-034 ALU_MD_DIV_EN undefined, DIV 100/7 -> md_done_o one cycle after accept, md_result_o = 0.

Source files
------------

// File: rtl/alu_md_sequencer_pkg.sv
// Shared definitions for the ALU decoder / multiply-divide sequencer:
// ALU opcodes, main-control class encodings, MD funct3 codes, FSM states.
package alu_md_sequencer_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_opcode_e;

    localparam logic [2:0] CLS_R      = 3'b000;
    localparam logic [2:0] CLS_I      = 3'b001;
    localparam logic [2:0] CLS_LDST   = 3'b010;
    localparam logic [2:0] CLS_BRANCH = 3'b011;
    localparam logic [2:0] CLS_LUI    = 3'b100;

    localparam logic [6:0] FUNCT7_MD = 7'b0000001;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/alu_md_sequencer_md_iter_unit.sv
// Iterative multiply/divide datapath: magnitude operands, shared hi/lo
// accumulator, step counter. Divide stepping only with ALU_MD_DIV_EN.
module md_iter_unit
    import alu_md_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   hi_q, lo_q, opb_q;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic               neg_q;
    logic               s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
`ifdef ALU_MD_DIV_EN
    logic               neg_rem_q;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   quo, rem;
`endif

    // Operand signs by op, then magnitudes fed to the unsigned core
    always_comb begin
        s1 = 1'b0;
        s2 = 1'b0;
        case (funct3)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                s1 = rs1[WIDTH-1];
                s2 = rs2[WIDTH-1];
            end
            MD_MULHSU: s1 = rs1[WIDTH-1];
            default: ;
        endcase
        mag1 = s1 ? -rs1 : rs1;
        mag2 = s2 ? -rs2 : rs2;
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = '0;
`ifdef ALU_MD_DIV_EN
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opb_q};
        if (op_q[2]) begin
            // extra top bit keeps a zero divisor from ever borrowing
            if (!diff[WIDTH+1]) begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else
`endif
        begin
            sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the post-step accumulator, registered by the caller
    always_comb begin
        prod   = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        result = (op_q == MD_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef ALU_MD_DIV_EN
        quo = neg_q ? -lo_d : lo_d;
        rem = neg_rem_q ? -hi_d : hi_d;
        if (op_q[2]) begin
            result = op_q[1] ? rem : quo;
        end
`endif
    end

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Load operands on start, advance one step per enabled cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
`ifdef ALU_MD_DIV_EN
            neg_rem_q <= 1'b0;
`endif
        end else if (start) begin
            hi_q      <= '0;
            lo_q      <= mag1;
            opb_q     <= mag2;
            cnt_q     <= '0;
            op_q      <= funct3;
            // divide by zero keeps an all-ones quotient regardless of sign
            neg_q     <= (s1 ^ s2) & ~(funct3[2] & ~|rs2);
`ifdef ALU_MD_DIV_EN
            neg_rem_q <= s1;
`endif
        end else if (step) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/alu_md_sequencer.sv
// ALU opcode decoder plus multi-cycle multiply/divide sequencer FSM.
// Define ALU_MD_DIV_EN to build divide hardware; otherwise divides
// complete in one cycle with a zero result.
module alu_md_sequencer
    import alu_md_sequencer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          funct7_i,
    input  logic [2:0]          funct3_i,
    input  logic [ALU_OP_W-1:0] ALU_Op_i,
    input  logic                valid_i,
    input  logic [WIDTH-1:0]    rs1_i,
    input  logic [WIDTH-1:0]    rs2_i,
    output logic [3:0]          ALU_Operation_o,
    output logic                stall_o,
    output logic                md_done_o,
    output logic [WIDTH-1:0]    md_result_o
);

`ifdef ALU_MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    md_state_e        state_q, state_d;
    alu_opcode_e      alu_op;
    logic             is_r, is_i, md_dec;
    logic             unit_start, unit_step, unit_last;
    logic [WIDTH-1:0] unit_result;

    assign is_r   = (ALU_Op_i == ALU_OP_W'(CLS_R));
    assign is_i   = (ALU_Op_i == ALU_OP_W'(CLS_I));
    assign md_dec = is_r && (funct7_i == FUNCT7_MD);

    // ALU opcode decode from instruction class, funct3 and funct7
    always_comb begin
        alu_op = ALU_ADD;
        if ((is_r && !md_dec) || is_i) begin
            case (funct3_i)
                3'b000:  alu_op = (is_r && funct7_i[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7_i[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end else if (ALU_Op_i == ALU_OP_W'(CLS_BRANCH)) begin
            alu_op = ALU_SUB;
        end else if (ALU_Op_i == ALU_OP_W'(CLS_LUI)) begin
            alu_op = ALU_PASS_B;
        end
        ALU_Operation_o = alu_op;
    end

    assign stall_o = valid_i && md_dec && (state_q != ST_DONE);

    // Next-state and control for the IDLE/CALC/DONE sequencer
    always_comb begin
        state_d    = state_q;
        unit_start = 1'b0;
        unit_step  = 1'b0;
        md_done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i && md_dec) begin
                    if (funct3_i[2] && !DIV_EN) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_CALC;
                        unit_start = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                unit_step = 1'b1;
                if (unit_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                md_done_o = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result is captured on entry to DONE so it is valid with md_done_o
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_result_o <= '0;
        end else if (state_q == ST_CALC && unit_last) begin
            md_result_o <= unit_result;
        end else if (state_q == ST_IDLE && state_d == ST_DONE) begin
            md_result_o <= '0;
        end
    end

    md_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (unit_start),
        .step   (unit_step),
        .funct3 (funct3_i),
        .rs1    (rs1_i),
        .rs2    (rs2_i),
        .last   (unit_last),
        .result (unit_result)
    );

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Directed table-driven bench for alu_md_sequencer (WIDTH=32). Divide
// expectations follow ALU_MD_DIV_EN as seen by this compile.
module tb_alu_md_sequencer;

`ifdef ALU_MD_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [6:0]  funct7_i;
    logic [2:0]  funct3_i;
    logic [2:0]  ALU_Op_i;
    logic        valid_i;
    logic [31:0] rs1_i, rs2_i;
    logic [3:0]  ALU_Operation_o;
    logic        stall_o, md_done_o;
    logic [31:0] md_result_o;

    int checks   = 0;
    int failures = 0;

    alu_md_sequencer #(
        .WIDTH    (32),
        .ALU_OP_W (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .funct7_i        (funct7_i),
        .funct3_i        (funct3_i),
        .ALU_Op_i        (ALU_Op_i),
        .valid_i         (valid_i),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .ALU_Operation_o (ALU_Operation_o),
        .stall_o         (stall_o),
        .md_done_o       (md_done_o),
        .md_result_o     (md_result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cls;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] exp_op;
    } dec_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_en;
    } md_vec_t;

    dec_vec_t dec_tab[19];
    md_vec_t  md_tab[18];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Issue one MD op at a negedge and follow it to md_done_o
    task automatic md_run(input int idx, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int          stall_cnt = 0;
        int          done_at   = -1;
        logic [31:0] got       = '0;
        valid_i  = 1'b1;
        ALU_Op_i = 3'b000;
        funct7_i = 7'b0000001;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            if (c == 1) begin
                rs1_i = ~a;
                rs2_i = b ^ 32'h5A5A_5A5A;
            end
            #1;
            if (c == 0) check($sformatf("md[%0d] alu_op", idx), ALU_Operation_o, 4'b0000);
            if (stall_o) stall_cnt++;
            if (md_done_o) begin
                done_at = c;
                got     = md_result_o;
            end
            @(negedge clk);
        end
        valid_i = 1'b0;
        #1;
        check($sformatf("md[%0d] done_cycle", idx), done_at, lat);
        check($sformatf("md[%0d] stall_cycles", idx), stall_cnt, lat);
        check($sformatf("md[%0d] result", idx), got, exp);
        check($sformatf("md[%0d] done_pulse", idx), md_done_o, 1'b0);
        check($sformatf("md[%0d] result_held", idx), md_result_o, exp);
        @(negedge clk);
    endtask

    initial begin : main
        int dones;
        int bad;

        dec_tab[0]  = '{3'b000, 7'b0000000, 3'b000, 4'b0000};
        dec_tab[1]  = '{3'b000, 7'b0100000, 3'b000, 4'b0001};
        dec_tab[2]  = '{3'b000, 7'b0000000, 3'b001, 4'b0101};
        dec_tab[3]  = '{3'b000, 7'b0000000, 3'b010, 4'b1000};
        dec_tab[4]  = '{3'b000, 7'b0000000, 3'b011, 4'b1001};
        dec_tab[5]  = '{3'b000, 7'b0000000, 3'b100, 4'b0100};
        dec_tab[6]  = '{3'b000, 7'b0000000, 3'b101, 4'b0110};
        dec_tab[7]  = '{3'b000, 7'b0100000, 3'b101, 4'b0111};
        dec_tab[8]  = '{3'b000, 7'b0000000, 3'b110, 4'b0011};
        dec_tab[9]  = '{3'b000, 7'b0000000, 3'b111, 4'b0010};
        dec_tab[10] = '{3'b001, 7'b0100000, 3'b000, 4'b0000};
        dec_tab[11] = '{3'b001, 7'b0100000, 3'b101, 4'b0111};
        dec_tab[12] = '{3'b001, 7'b0000000, 3'b101, 4'b0110};
        dec_tab[13] = '{3'b001, 7'b0100000, 3'b111, 4'b0010};
        dec_tab[14] = '{3'b010, 7'b0100000, 3'b101, 4'b0000};
        dec_tab[15] = '{3'b011, 7'b0000000, 3'b000, 4'b0001};
        dec_tab[16] = '{3'b100, 7'b0000000, 3'b011, 4'b1010};
        dec_tab[17] = '{3'b101, 7'b0100000, 3'b000, 4'b0000};
        dec_tab[18] = '{3'b000, 7'b0000001, 3'b100, 4'b0000};

        md_tab[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        md_tab[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        md_tab[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        md_tab[3]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        md_tab[4]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        md_tab[5]  = '{3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        md_tab[6]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        md_tab[7]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
        md_tab[8]  = '{3'b111, 32'd9,          32'd0,         32'd9};
        md_tab[9]  = '{3'b101, 32'd9,          32'd0,         32'hFFFF_FFFF};
        md_tab[10] = '{3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
        md_tab[11] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
        md_tab[12] = '{3'b100, 32'd100,        32'd7,         32'd14};
        md_tab[13] = '{3'b100, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2};
        md_tab[14] = '{3'b110, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE};
        md_tab[15] = '{3'b101, 32'd100,        32'd7,         32'd14};
        md_tab[16] = '{3'b111, 32'hFFFF_FFFF,  32'd10,        32'd5};
        md_tab[17] = '{3'b000, 32'h1234_5678,  32'h0000_0010, 32'h2345_6780};

        reset    = 1'b0;
        valid_i  = 1'b0;
        funct7_i = '0;
        funct3_i = '0;
        ALU_Op_i = '0;
        rs1_i    = '0;
        rs2_i    = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset md_result", md_result_o, 32'h0);
        check("reset md_done", md_done_o, 1'b0);
        check("reset stall", stall_o, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            ALU_Op_i = dec_tab[i].cls;
            funct7_i = dec_tab[i].f7;
            funct3_i = dec_tab[i].f3;
            #1;
            check($sformatf("dec[%0d] alu_op", i), ALU_Operation_o, dec_tab[i].exp_op);
            @(negedge clk);
        end

        // Valid non-MD instructions must leave the sequencer idle
        valid_i  = 1'b1;
        ALU_Op_i = 3'b000;
        funct7_i = 7'b0000000;
        funct3_i = 3'b000;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (stall_o || md_done_o) bad++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        check("non_md idle", bad, 0);

        for (int i = 0; i < 18; i++) begin
            if (md_tab[i].f3[2] && !DIV_ON)
                md_run(i, md_tab[i].f3, md_tab[i].a, md_tab[i].b, 32'h0, 1);
            else
                md_run(i, md_tab[i].f3, md_tab[i].a, md_tab[i].b, md_tab[i].exp_en, 33);
        end

        // Reset at CALC cycle 10 discards the multiply in flight
        valid_i  = 1'b1;
        ALU_Op_i = 3'b000;
        funct7_i = 7'b0000001;
        funct3_i = 3'b000;
        rs1_i    = 32'd7;
        rs2_i    = 32'hFFFF_FFFD;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midcalc reset result", md_result_o, 32'h0);
        check("midcalc reset done", md_done_o, 1'b0);
        check("midcalc reset stall_idle", stall_o, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        reset   = 1'b1;
        dones   = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (md_done_o) dones++;
            @(negedge clk);
        end
        check("midcalc no done", dones, 0);
        check("midcalc result stays", md_result_o, 32'h0);
        if (DIV_ON)
            md_run(100, 3'b100, 32'd100, 32'd7, 32'd14, 33);
        else
            md_run(100, 3'b100, 32'd100, 32'd7, 32'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
